// File: rtl/v_vram_burst_arb.sv
// Purpose: round-robin arbiter sharing one VRAM port between two burst requesters.
// Latency: grant cycle, then one beat/cycle; read data returns 2..1+B cycles after accept.
// Backpressure: requests wait for reqN_ready; responses have none (requesters must sink every beat).
module v_vram_burst_arb #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 256,
    parameter int LEN_W       = 4,
    parameter int ADDR_STRIDE = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [LEN_W-1:0]  req0_len,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic [DATA_W-1:0] req0_wmask,
    output logic              req0_wbeat,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_last,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [LEN_W-1:0]  req1_len,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic [DATA_W-1:0] req1_wmask,
    output logic              req1_wbeat,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_last,
    output logic              vram_r_ena,
    output logic [ADDR_W-1:0] vram_r_addr,
    input  logic [DATA_W-1:0] vram_r_data,
    output logic              vram_w_ena,
    output logic [ADDR_W-1:0] vram_w_addr,
    output logic [DATA_W-1:0] vram_w_data,
    output logic [DATA_W-1:0] vram_w_mask,
    output logic              busy
);

    typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

    state_t            state_q;
    logic              last_q;      // port granted most recently
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              rsp_vld_q;
    logic              rsp_last_q;
    logic              rsp_owner_q;

    logic grant_vld;
    logic grant_port;
    logic rd_issue;
    logic wr_issue;
    logic last_beat;

    // Arbitration: alternate when both request, otherwise take whichever is valid.
    // Gated with rst so nothing is granted while reset is held.
    always_comb begin
        grant_vld  = rst && (state_q == S_IDLE) && (req0_valid || req1_valid);
        grant_port = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    end

    assign rd_issue  = (state_q == S_BURST) && !we_q;
    assign wr_issue  = (state_q == S_BURST) && we_q;
    assign last_beat = (cnt_q == len_q);

    // Burst FSM: latch the granted request, then walk its beats one per cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_vld) begin
                        owner_q <= grant_port;
                        last_q  <= grant_port;
                        we_q    <= grant_port ? req1_we   : req0_we;
                        addr_q  <= grant_port ? req1_addr : req0_addr;
                        len_q   <= grant_port ? req1_len  : req0_len;
                        cnt_q   <= '0;
                        state_q <= S_BURST;
                    end
                end
                S_BURST: begin
                    addr_q <= addr_q + ADDR_W'(ADDR_STRIDE);
                    cnt_q  <= cnt_q + 1'b1;
                    if (last_beat) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Read-return tag pipeline: matches the one-cycle VRAM read latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_vld_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_owner_q <= 1'b0;
        end else begin
            rsp_vld_q   <= rd_issue;
            rsp_last_q  <= rd_issue && last_beat;
            rsp_owner_q <= owner_q;
        end
    end

    assign req0_ready  = grant_vld && !grant_port;
    assign req1_ready  = grant_vld && grant_port;
    assign req0_wbeat  = wr_issue && !owner_q;
    assign req1_wbeat  = wr_issue && owner_q;

    assign vram_r_ena  = rd_issue;
    assign vram_r_addr = rd_issue ? addr_q : '0;
    assign vram_w_ena  = wr_issue;
    assign vram_w_addr = wr_issue ? addr_q : '0;
    // Write data/mask are forwarded from the owner in the same cycle they are consumed.
    assign vram_w_data = !wr_issue ? '0 : (owner_q ? req1_wdata : req0_wdata);
    assign vram_w_mask = !wr_issue ? '0 : (owner_q ? req1_wmask : req0_wmask);

    assign rsp0_valid  = rsp_vld_q && !rsp_owner_q;
    assign rsp1_valid  = rsp_vld_q && rsp_owner_q;
    assign rsp0_last   = rsp_last_q && !rsp_owner_q;
    assign rsp1_last   = rsp_last_q && rsp_owner_q;
    assign rsp0_data   = vram_r_data;
    assign rsp1_data   = vram_r_data;

    assign busy        = (state_q == S_BURST);

endmodule

// File: tb/tb_v_vram_burst_arb.sv
// Bench for v_vram_burst_arb: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
// Inputs are driven 1 time unit after the rising edge; outputs sampled on the falling edge.
module tb_v_vram_burst_arb;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic         req0_we = 1'b0, req1_we = 1'b0;
    logic [31:0]  req0_addr = '0, req1_addr = '0;
    logic [3:0]   req0_len = '0, req1_len = '0;
    logic [255:0] req0_wdata = '0, req1_wdata = '0;
    logic [255:0] req0_wmask = '0, req1_wmask = '0;
    logic         req0_wbeat, req1_wbeat;
    logic         rsp0_valid, rsp1_valid, rsp0_last, rsp1_last;
    logic [255:0] rsp0_data, rsp1_data;
    logic         vram_r_ena, vram_w_ena;
    logic [31:0]  vram_r_addr, vram_w_addr;
    logic [255:0] vram_r_data = '0;
    logic [255:0] vram_w_data, vram_w_mask;
    logic         busy;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    v_vram_burst_arb dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_len(req0_len), .req0_wdata(req0_wdata),
        .req0_wmask(req0_wmask), .req0_wbeat(req0_wbeat),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_last(rsp0_last),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_len(req1_len), .req1_wdata(req1_wdata),
        .req1_wmask(req1_wmask), .req1_wbeat(req1_wbeat),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_last(rsp1_last),
        .vram_r_ena(vram_r_ena), .vram_r_addr(vram_r_addr), .vram_r_data(vram_r_data),
        .vram_w_ena(vram_w_ena), .vram_w_addr(vram_w_addr),
        .vram_w_data(vram_w_data), .vram_w_mask(vram_w_mask),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // VRAM contents are a fixed function of the address so returned data identifies it.
    function automatic logic [255:0] mem_f(input logic [31:0] a);
        return {8{a ^ 32'h5A5A_0F0F}};
    endfunction

    initial forever begin
        @(posedge clk);
        vram_r_data <= mem_f(vram_r_addr);
    end

    // Fresh write data/mask every cycle so per-beat forwarding is observable.
    initial forever begin
        @(posedge clk);
        #1;
        req0_wdata = {8{$urandom}};
        req0_wmask = {8{$urandom}};
        req1_wdata = {8{$urandom}};
        req1_wmask = {8{$urandom}};
    end

    // ---------------- reference model ----------------
    // A granted burst is expanded into a queue of beats; one beat leaves per cycle.
    typedef struct packed {
        logic [31:0] addr;
        logic        owner;
        logic        we;
        logic        last;
    } beat_t;

    beat_t beat_q[$];
    beat_t rsp_pend = '0;
    logic  rsp_pend_vld = 1'b0;
    int    m_last = 1;

    function automatic int m_grant();
        if (!rst || beat_q.size() != 0) return -1;
        if (req0_valid && req1_valid) return (m_last == 1) ? 0 : 1;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            beat_q.delete();
            rsp_pend_vld = 1'b0;
            m_last = 1;
        end else if (beat_q.size() != 0) begin
            rsp_pend     = beat_q[0];
            rsp_pend_vld = !beat_q[0].we;
            void'(beat_q.pop_front());
        end else begin
            int g;
            rsp_pend_vld = 1'b0;
            g = m_grant();
            if (g >= 0) begin
                logic [31:0] a;
                logic        w;
                int          n;
                a = (g == 0) ? req0_addr : req1_addr;
                w = (g == 0) ? req0_we : req1_we;
                n = (g == 0) ? int'(req0_len) : int'(req1_len);
                for (int b = 0; b <= n; b++) begin
                    beat_t bt;
                    bt.addr  = a + 32'(b * 32);
                    bt.owner = (g == 1);
                    bt.we    = w;
                    bt.last  = (b == n);
                    beat_q.push_back(bt);
                end
                m_last = g;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            int    g;
            logic  has;
            beat_t cb;
            g   = m_grant();
            has = (beat_q.size() != 0);
            cb  = has ? beat_q[0] : '0;
            chk("ready0", req0_ready, g == 0);
            chk("ready1", req1_ready, g == 1);
            chk("busy", busy, has);
            chk("r_ena", vram_r_ena, has && !cb.we);
            chk("w_ena", vram_w_ena, has && cb.we);
            chk("mutex", vram_r_ena && vram_w_ena, 1'b0);
            chk("wbeat0", req0_wbeat, has && cb.we && !cb.owner);
            chk("wbeat1", req1_wbeat, has && cb.we && cb.owner);
            chk("rsp0_valid", rsp0_valid, rsp_pend_vld && !rsp_pend.owner);
            chk("rsp1_valid", rsp1_valid, rsp_pend_vld && rsp_pend.owner);
            chk("rsp0_last", rsp0_last, rsp_pend_vld && !rsp_pend.owner && rsp_pend.last);
            chk("rsp1_last", rsp1_last, rsp_pend_vld && rsp_pend.owner && rsp_pend.last);
            if (has && !cb.we) chk("r_addr", vram_r_addr, cb.addr);
            if (has && cb.we) begin
                chk("w_addr", vram_w_addr, cb.addr);
                chk("w_data", vram_w_data, cb.owner ? req1_wdata : req0_wdata);
                chk("w_mask", vram_w_mask, cb.owner ? req1_wmask : req0_wmask);
            end
            if (rsp_pend_vld && !rsp_pend.owner) chk("rsp0_data", rsp0_data, mem_f(rsp_pend.addr));
            if (rsp_pend_vld && rsp_pend.owner)  chk("rsp1_data", rsp1_data, mem_f(rsp_pend.addr));
            if (!rst) begin
                chk("rst_r_addr", vram_r_addr, '0);
                chk("rst_w_addr", vram_w_addr, '0);
                chk("rst_w_data", vram_w_data, '0);
                chk("rst_w_mask", vram_w_mask, '0);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_grant(output int g);
        g = 2;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req0_ready) begin g = 0; break; end
            if (req1_ready) begin g = 1; break; end
        end
        if (g == 2) chk("grant_timeout", 1'b1, 1'b0);
    endtask

    // Presents a request and returns just after the edge that accepted it,
    // so the next falling edge is the first beat cycle.
    task automatic send(input int port, input logic we, input logic [31:0] addr,
                        input logic [3:0] len, output int ok);
        @(posedge clk);
        #1;
        if (port == 0) begin
            req0_we = we; req0_addr = addr; req0_len = len; req0_valid = 1'b1;
        end else begin
            req1_we = we; req1_addr = addr; req1_len = len; req1_valid = 1'b1;
        end
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((port == 0 && req0_ready) || (port == 1 && req1_ready)) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) chk("send_timeout", 1'b1, 1'b0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        int g;
        int ok;
        logic [31:0] tbl[4];

        // Reset held: a valid request must not be acknowledged.
        req0_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp0", rsp0_valid, 1'b0);
        req0_valid = 1'b0;
        #1 rst = 1'b1;

        // Both ports at once after reset: 0, 1, then 0 again, then 1.
        @(posedge clk);
        #1;
        req0_we = 1'b0; req0_addr = 32'h300; req0_len = 4'd0; req0_valid = 1'b1;
        req1_we = 1'b0; req1_addr = 32'h400; req1_len = 4'd0; req1_valid = 1'b1;
        wait_grant(g); chk("rr_first", g, 0);
        @(posedge clk); #1 req0_valid = 1'b0;
        wait_grant(g); chk("rr_second", g, 1);
        @(posedge clk); #1 req0_valid = 1'b1;
        wait_grant(g); chk("rr_third", g, 0);
        @(posedge clk); #1 req0_valid = 1'b0;
        wait_grant(g); chk("rr_fourth", g, 1);
        @(posedge clk); #1 req1_valid = 1'b0;

        // Single read burst of 4 beats from 0x100.
        tbl = '{32'h100, 32'h120, 32'h140, 32'h160};
        send(0, 1'b0, 32'h100, 4'd3, ok);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("t1_r_ena", vram_r_ena, k <= 4);
            if (k <= 4) chk("t1_r_addr", vram_r_addr, tbl[k-1]);
            chk("t1_rsp0_valid", rsp0_valid, k >= 2);
            chk("t1_rsp0_last", rsp0_last, k == 5);
        end

        // Two-beat write burst from port 1.
        tbl = '{32'h40, 32'h60, 32'h0, 32'h0};
        send(1, 1'b1, 32'h40, 4'd1, ok);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t3_w_ena", vram_w_ena, 1'b1);
            chk("t3_w_addr", vram_w_addr, tbl[k]);
            chk("t3_w_data", vram_w_data, req1_wdata);
            chk("t3_w_mask", vram_w_mask, req1_wmask);
            chk("t3_wbeat1", req1_wbeat, 1'b1);
            chk("t3_wbeat0", req0_wbeat, 1'b0);
            chk("t3_r_ena", vram_r_ena, 1'b0);
        end
        @(negedge clk);
        chk("t3_w_done", vram_w_ena, 1'b0);

        // Address wraps past the top of the space.
        send(0, 1'b0, 32'hFFFF_FFE0, 4'd1, ok);
        @(negedge clk); chk("t4_addr0", vram_r_addr, 32'hFFFF_FFE0);
        @(negedge clk); chk("t4_addr1", vram_r_addr, 32'h0);

        // Longest burst: 16 beats, single last.
        begin
            int nbusy, nrsp, nlast, last_idx;
            nbusy = 0; nrsp = 0; nlast = 0; last_idx = -1;
            send(0, 1'b0, 32'h1000, 4'd15, ok);
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (busy) nbusy++;
                if (rsp0_valid) begin
                    if (rsp0_last) begin nlast++; last_idx = nrsp; end
                    nrsp++;
                end
            end
            chk("t6_busy_cycles", nbusy, 16);
            chk("t6_rsp_beats", nrsp, 16);
            chk("t6_last_count", nlast, 1);
            chk("t6_last_index", last_idx, 15);
        end

        // Reset during the second beat of a 4-beat read.
        send(0, 1'b0, 32'h200, 4'd3, ok);
        @(negedge clk);
        @(negedge clk);
        chk("t5_busy_before", busy, 1'b1);
        #1 rst = 1'b0;
        #1;
        chk("t5_r_ena", vram_r_ena, 1'b0);
        chk("t5_rsp0", rsp0_valid, 1'b0);
        chk("t5_busy", busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t5_rsp0_after", rsp0_valid, 1'b0);
        chk("t5_busy_after", busy, 1'b0);

        // Round-robin pointer restarts favouring port 0.
        @(posedge clk);
        #1;
        req0_we = 1'b0; req0_addr = 32'h500; req0_len = 4'd1; req0_valid = 1'b1;
        req1_we = 1'b0; req1_addr = 32'h600; req1_len = 4'd0; req1_valid = 1'b1;
        wait_grant(g); chk("t5_rr_first", g, 0);
        @(posedge clk); #1 req0_valid = 1'b0;
        wait_grant(g); chk("t5_rr_second", g, 1);
        @(posedge clk); #1 req1_valid = 1'b0;

        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
